// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Buffers ALU commands, issues them one per cycle to an external fixed-latency
//   ALU, and collects the ALU results into a response FIFO.
//
//   Handshake semantics (both channels): a transfer happens on the rising edge
//   where valid && ready are both high. cmd_ready depends only on command FIFO
//   occupancy; rsp_valid depends only on response FIFO occupancy. Neither ready
//   nor valid is combinationally derived from the partner's valid/ready.
//
//   Ports
//     clk, rst                     clock, asynchronous active-high reset
//     cmd_valid/cmd_ready          command channel
//     cmd_opcode, cmd_a, cmd_b,
//     cmd_shift                    command payload (0=ADD 1=SUB 2=MUL 3=NAND)
//     alu_opcode, alu_input1,
//     alu_input2, alu_shiftValue   registered drive to the ALU (opcode 4'hF = bubble)
//     alu_result, alu_carry        ALU outputs, valid ALU_LAT cycles after drive
//     rsp_valid/rsp_ready          response channel
//     rsp_data, rsp_carry          head response (combinational from storage)
module alu_issue_queue #(
  parameter int WIDTH     = 64,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int ALU_LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [4:0]       cmd_shift,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int IW  = $clog2(ALU_LAT + 1);
  localparam logic [3:0] OP_BUBBLE = 4'hF;

  // Command FIFO
  logic [3:0]       cmd_op_mem [CMD_DEPTH];
  logic [WIDTH-1:0] cmd_a_mem  [CMD_DEPTH];
  logic [WIDTH-1:0] cmd_b_mem  [CMD_DEPTH];
  logic [4:0]       cmd_sh_mem [CMD_DEPTH];
  logic [CAW-1:0]   cmd_wr_ptr;
  logic [CAW-1:0]   cmd_rd_ptr;
  logic [CAW:0]     cmd_count;
  logic             cmd_push;
  logic             cmd_issue;

  // Head command decode: class bit 1 = carry is meaningful (ADD/SUB),
  // class bit 0 = defined opcode (result passed through, else forced 0).
  logic [3:0]       head_op;
  logic [1:0]       head_cls;

  // Issue tracking
  logic [IW-1:0]    inflight;
  logic [ALU_LAT-1:0] pipe_v;
  logic [1:0]       pipe_cls [ALU_LAT];
  logic             capture;
  logic [1:0]       cap_cls;
  logic [31:0]      occupancy;

  // Response FIFO
  logic [WIDTH-1:0] rsp_data_mem  [RSP_DEPTH];
  logic             rsp_carry_mem [RSP_DEPTH];
  logic [RAW-1:0]   rsp_wr_ptr;
  logic [RAW-1:0]   rsp_rd_ptr;
  logic [RAW:0]     rsp_count;
  logic             rsp_pop;

  assign cmd_ready = (cmd_count != (CAW+1)'(CMD_DEPTH));
  assign cmd_push  = cmd_valid && cmd_ready;

  assign head_op  = cmd_op_mem[cmd_rd_ptr];
  assign head_cls = {(head_op == 4'd0) || (head_op == 4'd1), head_op < 4'd4};

  // Credit check: every issued command has a reserved response slot, so the
  // ALU never needs to stall and captures never find the FIFO full.
  assign occupancy = 32'(inflight) + 32'(rsp_count);
  assign cmd_issue = (cmd_count != '0) && (occupancy < 32'(RSP_DEPTH));

  assign capture = pipe_v[ALU_LAT-1];
  assign cap_cls = pipe_cls[ALU_LAT-1];

  assign rsp_valid = (rsp_count != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_data_mem[rsp_rd_ptr];
  assign rsp_carry = rsp_carry_mem[rsp_rd_ptr];

  // Command storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_op_mem[cmd_wr_ptr] <= cmd_opcode;
      cmd_a_mem[cmd_wr_ptr]  <= cmd_a;
      cmd_b_mem[cmd_wr_ptr]  <= cmd_b;
      cmd_sh_mem[cmd_wr_ptr] <= cmd_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (cmd_push)  cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
      if (cmd_issue) cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
      case ({cmd_push, cmd_issue})
        2'b10:   cmd_count <= cmd_count + (CAW+1)'(1);
        2'b01:   cmd_count <= cmd_count - (CAW+1)'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // ALU drive registers: operands hold through bubbles, opcode goes to 4'hF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode     <= OP_BUBBLE;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
    end else if (cmd_issue) begin
      alu_opcode     <= head_op;
      alu_input1     <= cmd_a_mem[cmd_rd_ptr];
      alu_input2     <= cmd_b_mem[cmd_rd_ptr];
      alu_shiftValue <= cmd_sh_mem[cmd_rd_ptr];
    end else begin
      alu_opcode     <= OP_BUBBLE;
    end
  end

  // Valid/class pipe mirrors the ALU latency; the last stage marks the edge on
  // which alu_result belongs to an issued command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v   <= '0;
      inflight <= '0;
      for (int i = 0; i < ALU_LAT; i++) pipe_cls[i] <= '0;
    end else begin
      pipe_v[0]   <= cmd_issue;
      pipe_cls[0] <= head_cls;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_cls[i] <= pipe_cls[i-1];
      end
      case ({cmd_issue, capture})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        rsp_data_mem[i]  <= '0;
        rsp_carry_mem[i] <= 1'b0;
      end
    end else begin
      if (capture) begin
        rsp_data_mem[rsp_wr_ptr]  <= cap_cls[0] ? alu_result : '0;
        rsp_carry_mem[rsp_wr_ptr] <= cap_cls[1] & alu_carry;
        rsp_wr_ptr                <= rsp_wr_ptr + RAW'(1);
      end
      if (rsp_pop) rsp_rd_ptr <= rsp_rd_ptr + RAW'(1);
      case ({capture, rsp_pop})
        2'b10:   rsp_count <= rsp_count + (RAW+1)'(1);
        2'b01:   rsp_count <= rsp_count - (RAW+1)'(1);
        default: rsp_count <= rsp_count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue
//   Drives alu_issue_queue with directed and random commands, models the
//   external ALU, and checks every response against a reference computed from
//   the opcode rules.
module tb_alu_issue_queue;

  localparam int WIDTH     = 64;
  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int ALU_LAT   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [4:0]       cmd_shift;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_input1;
  logic [WIDTH-1:0] alu_input2;
  logic [4:0]       alu_shiftValue;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH:0] exp_q[$];
  bit stim_done;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  alu_issue_queue #(
    .WIDTH(WIDTH), .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference and ALU model ----------------
  // Expected response {carry, data}: what the consumer must see per opcode.
  function automatic logic [WIDTH:0] ref_rsp(input logic [3:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] w;
    case (op)
      4'd0:    w = {1'b0, a} + {1'b0, b};
      4'd1:    w = {1'b0, a} - {1'b0, b};   // top bit is the borrow
      4'd2:    w = {1'b0, a * b};
      4'd3:    w = {1'b0, ~(a & b)};
      default: w = '0;
    endcase
    return w;
  endfunction

  // External ALU: correct arithmetic for 0..3, but a junk carry flag for
  // MUL/NAND and junk data for undefined opcodes, so the queue must mask them.
  function automatic logic [WIDTH:0] alu_model(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] w;
    case (op)
      4'd0:    w = {1'b0, a} + {1'b0, b};
      4'd1:    w = {1'b0, a} - {1'b0, b};
      4'd2:    w = {~(a[0] ^ b[0]), a * b};
      4'd3:    w = {1'b1, ~(a & b)};
      default: w = {1'b1, a ^ b ^ 64'h5A5A_0000_0000_A5A5};
    endcase
    return w;
  endfunction

  // ALU_LAT-1 register stages: result valid ALU_LAT cycles after the drive edge
  // is sampled by the queue on the following edge.
  logic [WIDTH:0] alu_stage [ALU_LAT-1];
  always @(posedge clk) begin
    alu_stage[0] <= alu_model(alu_opcode, alu_input1, alu_input2);
    for (int i = 1; i < ALU_LAT-1; i++) alu_stage[i] <= alu_stage[i-1];
  end
  assign {alu_carry, alu_result} = alu_stage[ALU_LAT-2];

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [WIDTH:0] e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected got=%h exp=none t=%0t", {rsp_carry, rsp_data}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_order", {rsp_carry, rsp_data}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Holds a command until it is accepted; returns 1 time unit after the accept edge.
  task automatic push(input logic [3:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [4:0] sh);
    bit done = 1'b0;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_shift  = sh;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back(ref_rsp(op, a, b));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("push_accepted", 65'(done), 65'(1));
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", 65'(exp_q.size()), 65'(0));
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return ALL_ONES;
      1:       return WIDTH'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_shift  = '0;
    rsp_ready  = 1'b0;
    stim_done  = 1'b0;
    cycles(3);

    // Reset values
    chk("rst_cmd_ready", 65'(cmd_ready), 65'(1));
    chk("rst_rsp_valid", 65'(rsp_valid), 65'(0));
    chk("rst_alu_opcode", 65'(alu_opcode), 65'(4'hF));
    chk("rst_alu_inputs", {1'b0, alu_input1 | alu_input2}, 65'(0));
    chk("rst_alu_shift", 65'(alu_shiftValue), 65'(0));
    chk("rst_rsp_head", {rsp_carry, rsp_data}, 65'(0));
    rst = 1'b0;

    // All-ones + 1: latency, drive registers, wrap to zero with carry
    rsp_ready = 1'b1;
    push(4'd0, ALL_ONES, 64'd1, 5'd17);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("issue_opcode", 65'(alu_opcode), 65'(4'd0));
        chk("issue_input1", {1'b0, alu_input1}, {1'b0, ALL_ONES});
        chk("issue_shift", 65'(alu_shiftValue), 65'(5'd17));
      end
      if (k == 2) begin
        chk("bubble_opcode", 65'(alu_opcode), 65'(4'hF));
        chk("bubble_hold_input1", {1'b0, alu_input1}, {1'b0, ALL_ONES});
      end
      chk("latency_rsp_valid", 65'(rsp_valid), 65'(k == 3));
    end
    chk("add_wrap_data_carry", {rsp_carry, rsp_data}, {1'b1, 64'd0});
    drain(20);

    // Back-to-back SUB, MUL, NAND
    push(4'd1, 64'd5, 64'd7, 5'd0);
    push(4'd2, 64'd3, 64'd4, 5'd1);
    push(4'd3, 64'hF0, 64'hFF, 5'd2);
    drain(20);

    // Undefined opcode
    push(4'd9, 64'd1, 64'd1, 5'd3);
    drain(20);

    // Back-pressure: 4 buffered responses, 4 queued commands, then release
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(4'd0, 64'(i * 3), 64'(100 + i), 5'(i));
    cycles(4);
    chk("bp_cmd_ready", 65'(cmd_ready), 65'(0));
    chk("bp_alu_opcode", 65'(alu_opcode), 65'(4'hF));
    chk("bp_rsp_valid", 65'(rsp_valid), 65'(1));
    rsp_ready = 1'b1;
    push(4'd0, ALL_ONES, 64'd2, 5'd8);
    push(4'd0, 64'd40, 64'd2, 5'd9);
    drain(40);

    // Reset with commands queued and in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(4'd0, 64'(i), 64'd1, 5'd0);
    cycles(4);
    // two pops free two credits: two issues go in flight while one more is queued
    rsp_ready  = 1'b1;
    cmd_valid  = 1'b1;
    cmd_opcode = 4'd0;
    cmd_a      = 64'd77;
    cmd_b      = 64'd1;
    cycles(1);
    cmd_valid  = 1'b0;
    cycles(1);
    rsp_ready  = 1'b0;
    cmd_valid  = 1'b1;
    cycles(1);
    cmd_valid  = 1'b0;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_rsp_valid", 65'(rsp_valid), 65'(0));
    chk("midrst_cmd_ready", 65'(cmd_ready), 65'(1));
    chk("midrst_alu_opcode", 65'(alu_opcode), 65'(4'hF));
    chk("midrst_rsp_head", {rsp_carry, rsp_data}, 65'(0));
    cycles(2);
    rst = 1'b0;
    cycles(6);
    chk("no_stale_rsp", 65'(rsp_valid), 65'(0));
    // First command right after release
    rsp_ready = 1'b1;
    push(4'd1, 64'd9, 64'd4, 5'd0);
    drain(20);

    // Random traffic with random back-pressure
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [3:0] op;
          op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
          push(op, rand_operand(), rand_operand(), 5'($urandom_range(0, 31)));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          rsp_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        rsp_ready = 1'b1;
      end
    join
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
